// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller that sits between the execute stage and the data
// BRAM. It accepts one request at a time and derives the byte mask from
// func3 and the low address bits. It drives a single registered BRAM access,
// then waits out the BRAM read latency. For a load, it hands the raw word,
// func3 and byte mask to the byte-extraction stage. Misaligned requests and
// requests with an illegal func3 are rejected with an err pulse and never
// reach the BRAM.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; ready only while idle
//   req_we            1 = store, 0 = load
//   req_func3         RV32I load/store func3
//   req_addr          byte address (upper bits beyond the BRAM wrap)
//   req_wdata         store data (rs2)
//   bram_en/we/addr/wdata, bram_rdata   BRAM port
//   rd_valid          pulse: rd_data/rd_func3/rd_byte_mask valid
//   rd_data           raw BRAM word, unshifted
//   rd_func3          func3 of the completed load
//   rd_byte_mask      byte mask of the completed load
//   st_done           pulse: store written
//   err               pulse: misaligned or illegal access, no BRAM access
//   busy              ~req_ready, stalls the pipeline
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int BRAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_func3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_wdata,
  input  logic [31:0]           bram_rdata,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  output logic [2:0]            rd_func3,
  output logic [3:0]            rd_byte_mask,
  output logic                  st_done,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            func3_q, func3_d;
  logic [3:0]            mask_q, mask_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  bram_en_q, bram_en_d;
  logic [3:0]            bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [31:0]           bram_wdata_q, bram_wdata_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic [2:0]            rd_func3_q, rd_func3_d;
  logic [3:0]            rd_mask_q, rd_mask_d;
  logic                  st_done_q, st_done_d;
  logic                  err_q, err_d;

  logic [1:0]            byte_off;
  logic [3:0]            req_mask;
  logic                  req_bad;
  logic [31:0]           wdata_rep;
  logic                  unused_addr_bits;

  assign byte_off = req_addr[1:0];

  // Address bits above the BRAM word address are ignored, so accesses wrap.
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Request decode: byte mask, lane-replicated store data and legality.
  // func3[1:0] carries the access size; func3[2] is the unsigned flag,
  // which only exists for byte and half loads.
  always_comb begin
    req_mask  = 4'b0000;
    req_bad   = 1'b0;
    wdata_rep = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        req_mask  = 4'b0001 << byte_off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_mask  = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
        req_bad   = byte_off[0];
      end
      2'b10: begin
        req_mask = 4'b1111;
        req_bad  = (byte_off != 2'b00);
      end
      default: req_bad = 1'b1;
    endcase
    if (req_we && req_func3[2]) begin
      req_bad = 1'b1;
    end
    if (req_func3 == 3'b110) begin
      req_bad = 1'b1;
    end
  end

  // Next-state and registered-output logic. The BRAM strobes, st_done and
  // err are pulses, so they default to zero each cycle. The rd_* fields hold
  // until the next load completes.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    func3_d      = func3_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    bram_en_d    = 1'b0;
    bram_we_d    = 4'b0000;
    bram_addr_d  = '0;
    bram_wdata_d = 32'h0;
    st_done_d    = 1'b0;
    err_d        = 1'b0;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    rd_func3_d   = rd_func3_q;
    rd_mask_d    = rd_mask_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            we_d        = req_we;
            func3_d     = req_func3;
            mask_d      = req_mask;
            bram_en_d   = 1'b1;
            bram_addr_d = req_addr[ADDR_WIDTH+1:2];
            if (req_we) begin
              bram_we_d    = req_mask;
              bram_wdata_d = wdata_rep;
              st_done_d    = 1'b1;
            end
          end
        end
      end

      // A one-cycle latency BRAM already has data in the cycle after ACCESS.
      // In that case WAIT has zero cycles to count, so ACCESS goes straight
      // to RESP.
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else if (BRAM_LATENCY > 1) begin
          state_d = WAIT;
          cnt_d   = 2'(BRAM_LATENCY - 1);
        end else begin
          state_d = RESP;
        end
      end

      WAIT: begin
        if (cnt_q <= 2'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      RESP: begin
        state_d    = IDLE;
        rd_valid_d = 1'b1;
        rd_data_d  = bram_rdata;
        rd_func3_d = func3_q;
        rd_mask_d  = mask_q;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      func3_q      <= 3'b000;
      mask_q       <= 4'b0000;
      cnt_q        <= 2'd0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 4'b0000;
      bram_addr_q  <= '0;
      bram_wdata_q <= 32'h0;
      st_done_q    <= 1'b0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 32'h0;
      rd_func3_q   <= 3'b000;
      rd_mask_q    <= 4'b0000;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      func3_q      <= func3_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      st_done_q    <= st_done_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_func3_q   <= rd_func3_d;
      rd_mask_q    <= rd_mask_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = ~req_ready;
  assign bram_en      = bram_en_q;
  assign bram_we      = bram_we_q;
  assign bram_addr    = bram_addr_q;
  assign bram_wdata   = bram_wdata_q;
  assign st_done      = st_done_q;
  assign err          = err_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_func3     = rd_func3_q;
  assign rd_byte_mask = rd_mask_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller between the execute stage and the data BRAM, directly upstream of the load byte-extraction stage.
- Accepts one memory request at a time and computes the 4-bit byte mask from func3 and address.
- Issues the BRAM access, waits out the BRAM read latency and presents raw word, func3 and byte mask to the extraction stage.
- Detects misaligned and illegal-func3 accesses and stalls the core while busy.

Parameters:
- ADDR_WIDTH, 10, BRAM word-address width; byte address bits [ADDR_WIDTH+1:2] select the word, upper bits ignored (wrap).
- BRAM_LATENCY, 1, cycles from BRAM enable to valid bram_rdata; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_func3  in  3  RV32I load/store func3
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- bram_en  out  1  BRAM enable
- bram_we  out  4  BRAM per-byte write enable
- bram_addr  out  ADDR_WIDTH  BRAM word address
- bram_wdata  out  32  lane-replicated store data
- bram_rdata  in  32  BRAM read data
- rd_valid  out  1  one-cycle pulse: rd_data, rd_func3 and rd_byte_mask are valid
- rd_data  out  32  raw BRAM word, unshifted
- rd_func3  out  3  func3 of the completed load
- rd_byte_mask  out  4  byte mask of the completed load
- st_done  out  1  one-cycle pulse: store written
- err  out  1  one-cycle pulse: misaligned access or illegal func3; no BRAM access made
- busy  out  1  equals ~req_ready; stalls the pipeline

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE. req_ready = 1.
  - All other outputs are 0: bram_*, rd_*, st_done, err, busy.
  - Any in-flight access is discarded; no rd_valid or st_done is produced for it.
- FSM states: IDLE, ACCESS, WAIT, RESP. req_ready = 1 only in IDLE.
- Byte mask, with a = req_addr[1:0]:
  - Byte (000/100): 4'b0001 << a.
  - Half (001/101): a[1] ? 1100 : 0011. Misaligned if a[0] = 1.
  - Word (010): 1111. Misaligned if a != 0.
  - Loads: func3 011, 110 and 111 are illegal.
  - Stores: only func3 000, 001 and 010 are legal.
- Accept at cycle T in IDLE:
  - Misaligned or illegal request: err = 1 at T+1, outputs otherwise idle, back to IDLE at T+1 (req_ready high at T+1).
  - Legal request: go to ACCESS. All BRAM outputs are registered and valid for exactly cycle T+1.
    - bram_en = 1 and bram_addr = req_addr[ADDR_WIDTH+1:2].
    - Store: bram_we = mask. bram_wdata = {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, wdata for SW.
    - Load: bram_we = 0.
- Store: st_done = 1 at T+1; ACCESS returns to IDLE, so req_ready is high at T+2.
- Load:
  - ACCESS goes to WAIT. A latency counter counts BRAM_LATENCY-1 further cycles.
  - RESP samples bram_rdata at T+BRAM_LATENCY+1.
  - rd_valid = 1 at T+BRAM_LATENCY+2; back in IDLE that same cycle.
  - rd_data, rd_func3 and rd_byte_mask hold their values until the next load completes.
- Request fields are latched at acceptance. Input changes while busy are ignored.
- While busy, the requester must hold req_valid; no request is ever dropped or double-accepted.
- rd_valid, st_done and err are mutually exclusive and never asserted for consecutive requests without an intervening IDLE cycle.

Test Plan:
- Reset: hold rst_n = 0 mid-load (during WAIT), release -> req_ready = 1, rd_valid never pulses, BRAM outputs 0.
- SB at 0x0000_0006, wdata 0x1234_56AB -> at T+1: bram_en = 1, bram_addr = 1, bram_we = 0100, bram_wdata = 0xABAB_ABAB; st_done = 1; req_ready high at T+2.
- LH at 0x0000_000A, BRAM word 2 = 0xDEAD_BEEF, BRAM_LATENCY = 1 -> bram_addr = 2 at T+1; rd_valid at T+3 with rd_data = 0xDEAD_BEEF, rd_byte_mask = 1100, rd_func3 = 001.
- LW at 0x0000_0004 with BRAM_LATENCY = 2 -> rd_valid at T+4, rd_byte_mask = 1111; req_ready low T+1..T+3.
- Misaligned: LW at 0x0000_0002, SH at 0x0000_0001, load func3 = 011 -> each gives err = 1 at T+1, bram_en stays 0, req_ready high at T+1.
- Back-to-back: req_valid held high with SW then LBU queued -> the second request is accepted only in the first IDLE cycle after st_done; exactly one st_done and one rd_valid observed.
